// File: rtl/perm_pkg.sv
// Shared mode encoding and table helpers for the permutation/select pipeline.
package perm_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_PASS   = 3'd0,
        MODE_REV    = 3'd1,
        MODE_ROTL   = 3'd2,
        MODE_TABLE  = 3'd3,
        MODE_SELECT = 3'd4
    } mode_e;

    // Reset value of table entry idx: every output bit sources itself.
    function automatic int unsigned ident_entry(input int unsigned idx);
        return idx;
    endfunction

endpackage

// File: rtl/perm_core.sv
// Combinational bit-permutation / select datapath; no state, so it can be
// checked in isolation against reference permutations.
module perm_core
    import perm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [MODE_W-1:0]            mode_i,
    input  logic [WIDTH-1:0]             a_i,
    input  logic [WIDTH-1:0]             b_i,
    input  logic                         sel_i,
    input  logic [IDX_W-1:0]             rot_i,
    input  logic [WIDTH-1:0][IDX_W-1:0]  tbl_i,
    output logic [WIDTH-1:0]             res_o
);

    logic [IDX_W-1:0] src;

    always_comb begin
        res_o = '0;
        src   = '0;
        case (mode_i)
            MODE_PASS:   res_o = a_i;
            MODE_REV: begin
                for (int i = 0; i < WIDTH; i++) res_o[i] = a_i[WIDTH-1-i];
            end
            MODE_ROTL: begin
                // IDX_W-bit subtraction wraps modulo WIDTH since WIDTH is a power of two
                for (int i = 0; i < WIDTH; i++) begin
                    src      = IDX_W'(i) - rot_i;
                    res_o[i] = a_i[src];
                end
            end
            MODE_TABLE: begin
                for (int i = 0; i < WIDTH; i++) res_o[i] = a_i[tbl_i[i]];
            end
            MODE_SELECT: res_o = sel_i ? a_i : b_i;
            default:     res_o = '0;
        endcase
    end

endmodule

// File: rtl/perm_mux_pipe.sv
// Registered permutation/select stage: table registers, valid/ready output
// register, completed-beat counter and sticky reserved-mode flag.
module perm_mux_pipe
    import perm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_addr,
    input  logic [IDX_W-1:0]     cfg_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MODE_W-1:0]    in_mode,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_sel,
    input  logic [IDX_W-1:0]     in_rot,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CNT_W-1:0]     beat_count,
    output logic                 err
);

    logic [WIDTH-1:0][IDX_W-1:0] tbl_q;
    logic [WIDTH-1:0]            data_q, data_d, core_res;
    logic                        valid_q, valid_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        err_q, err_d;
    logic                        accept;

    perm_core #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_core (
        .mode_i (in_mode),
        .a_i    (in_a),
        .b_i    (in_b),
        .sel_i  (in_sel),
        .rot_i  (in_rot),
        .tbl_i  (tbl_q),
        .res_o  (core_res)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (accept) begin
            data_d  = core_res;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (valid_q && out_ready) cnt_d = cnt_q + 1'b1;
        if (accept && (in_mode > MODE_SELECT)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) tbl_q[i] <= IDX_W'(ident_entry(i));
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            // Beats accepted this cycle already sampled the old entry via core_res
            if (cfg_we) tbl_q[cfg_addr] <= cfg_data;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign beat_count = cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_perm_mux_pipe.sv
// Directed self-checking bench for perm_mux_pipe (8-bit instance plus a
// 16-bit instance for wide rotation).
module tb_perm_mux_pipe;
    import perm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr, cfg_data;
    logic        in_valid, in_ready, in_sel, out_valid, out_ready, err;
    logic [2:0]  in_mode, in_rot;
    logic [7:0]  in_a, in_b, out_data;
    logic [15:0] beat_count;

    logic        w_valid, w_ready, w_out_valid, w_err;
    logic [2:0]  w_mode;
    logic [3:0]  w_rot;
    logic [15:0] w_a, w_data, w_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    perm_mux_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
        .in_rot(in_rot), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .beat_count(beat_count), .err(err)
    );

    perm_mux_pipe #(.WIDTH(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .cfg_we(1'b0), .cfg_addr(4'd0),
        .cfg_data(4'd0), .in_valid(w_valid), .in_ready(w_ready),
        .in_mode(w_mode), .in_a(w_a), .in_b(16'h0000), .in_sel(1'b0),
        .in_rot(w_rot), .out_valid(w_out_valid), .out_ready(1'b1),
        .out_data(w_data), .beat_count(w_count), .err(w_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] mode, input logic [7:0] a);
        in_valid = 1'b1;
        in_mode  = mode;
        in_a     = a;
    endtask

    localparam logic [2:0] TBL [8] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd5, 3'd4, 3'd6, 3'd7};
    localparam logic [7:0] STREAM [3] = '{8'h22, 8'h33, 8'h44};

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_mode = '0; in_a = '0; in_b = '0; in_sel = 1'b0;
        in_rot = '0; out_ready = 1'b1;
        w_valid = 1'b0; w_mode = '0; w_a = '0; w_rot = '0;
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'h00);
        check("rst_count", 32'(beat_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        beat(MODE_PASS, 8'h3C);
        step();
        check("pass_valid", 32'(out_valid), 32'd1);
        check("pass_data", 32'(out_data), 32'h3C);
        beat(MODE_REV, 8'h01);
        step();
        check("rev_data", 32'(out_data), 32'h80);
        in_valid = 1'b0;
        step();
        check("idle_valid", 32'(out_valid), 32'd0);
        check("count2", 32'(beat_count), 32'd2);

        for (int i = 0; i < 8; i++) begin
            cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = TBL[i];
            step();
        end
        cfg_we = 1'b0;
        beat(MODE_TABLE, 8'h01);
        step();
        check("tbl_01", 32'(out_data), 32'h08);
        beat(MODE_TABLE, 8'h10);
        step();
        check("tbl_10", 32'(out_data), 32'h20);
        // write tbl[0]=0 in the same cycle a TABLE beat is accepted
        beat(MODE_TABLE, 8'h01);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 3'd0;
        step();
        cfg_we = 1'b0;
        check("tbl_old", 32'(out_data), 32'h08);
        beat(MODE_TABLE, 8'h01);
        step();
        check("tbl_new", 32'(out_data), 32'h09);

        beat(MODE_ROTL, 8'h81);
        in_rot = 3'd3;
        w_valid = 1'b1; w_mode = MODE_ROTL; w_a = 16'h8001; w_rot = 4'd15;
        step();
        check("rotl8", 32'(out_data), 32'h0C);
        check("rotl16", 32'(w_data), 32'hC000);
        w_valid = 1'b0;

        beat(MODE_SELECT, 8'hA5);
        in_b = 8'h5A; in_sel = 1'b1;
        step();
        check("sel1", 32'(out_data), 32'hA5);
        in_sel = 1'b0;
        step();
        check("sel0", 32'(out_data), 32'h5A);
        check("err_pre", 32'(err), 32'd0);
        beat(3'd6, 8'hFF);
        step();
        check("rsv_data", 32'(out_data), 32'h00);
        check("rsv_valid", 32'(out_valid), 32'd1);
        check("rsv_err", 32'(err), 32'd1);
        beat(MODE_PASS, 8'h5F);
        step();
        check("err_sticky_data", 32'(out_data), 32'h5F);
        check("err_sticky", 32'(err), 32'd1);
        in_valid = 1'b0;
        step();
        check("count11", 32'(beat_count), 32'd11);

        beat(MODE_PASS, 8'h11);
        out_ready = 1'b0;
        step();
        beat(MODE_PASS, 8'h22);
        for (int i = 0; i < 4; i++) begin
            check("bp_ready", 32'(in_ready), 32'd0);
            step();
            check("bp_data", 32'(out_data), 32'h11);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_count", 32'(beat_count), 32'd11);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat(MODE_PASS, STREAM[i]);
            step();
            check("stream_data", 32'(out_data), 32'(STREAM[i]));
            check("stream_count", 32'(beat_count), 32'(12 + i));
        end
        in_valid = 1'b0;
        step();
        check("stream_end_valid", 32'(out_valid), 32'd0);
        check("count15", 32'(beat_count), 32'd15);

        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 3'd5;
        step();
        cfg_we = 1'b0;
        beat(MODE_PASS, 8'h77);
        out_ready = 1'b0;
        step();
        check("hold_before_rst", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_data", 32'(out_data), 32'h00);
        check("mrst_count", 32'(beat_count), 32'd0);
        check("mrst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        beat(MODE_TABLE, 8'h01);
        step();
        check("tbl_ident", 32'(out_data), 32'h01);
        in_valid = 1'b0;
        step();
        check("post_rst_count", 32'(beat_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
